// File: rtl/arith_result_checker.sv
// Golden-model checker for the adder/multiplier test loop.
// Ports: i_clk/i_resetn, i_valid/i_clear, observed adder_*/mul_* operands and results,
//        o_pass_cnt/o_err_cnt/o_err_flags/o_first_fail_idx verdict, o_busy in-flight flag.
module arith_result_checker #(
    parameter int A           = 8,
    parameter int B           = 8,
    parameter int ADDER_0     = A + 1,
    parameter int MUL_0       = A + B,
    parameter int LAT         = 1,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_valid,
    input  logic               i_clear,
    input  logic [A-1:0]       adder_a,
    input  logic [B-1:0]       adder_b,
    input  logic [A-1:0]       mul_a,
    input  logic [B-1:0]       mul_b,
    input  logic [ADDER_0-1:0] adder_out,
    input  logic [MUL_0-1:0]   mul_out,
    output logic [CNT_W-1:0]   o_pass_cnt,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [1:0]         o_err_flags,
    output logic [CNT_W-1:0]   o_first_fail_idx,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                        r_state;
    logic [LAT-1:0]                r_vld;
    logic [LAT-1:0][ADDER_0-1:0]   r_add;
    logic [LAT-1:0][MUL_0-1:0]     r_mul;
    logic [CNT_W-1:0]              r_pass_cnt;
    logic [CNT_W-1:0]              r_err_cnt;
    logic [1:0]                    r_err_flags;
    logic [CNT_W-1:0]              r_first_fail_idx;

    logic [ADDER_0-1:0] w_exp_add;
    logic [MUL_0-1:0]   w_exp_mul;
    logic               w_add_bad;
    logic               w_mul_bad;
    logic               w_any_bad;
    logic               w_cmp_en;
    logic [CNT_W:0]     w_sum;
    logic [CNT_W-1:0]   w_idx;

    // Goldens are widened before the operation so carry and full product survive.
    assign w_exp_add = ADDER_0'(adder_a) + ADDER_0'(adder_b);
    assign w_exp_mul = MUL_0'(mul_a) * MUL_0'(mul_b);

    assign w_add_bad = r_add[LAT-1] != adder_out;
    assign w_mul_bad = r_mul[LAT-1] != mul_out;
    assign w_any_bad = w_add_bad | w_mul_bad;

    // A halted checker ignores the tail entirely; clear wins over any compare.
    assign w_cmp_en = r_vld[LAT-1] && (r_state != ST_HALT) && !i_clear;

    // Sample index saturates like the counters it is built from.
    assign w_sum = {1'b0, r_pass_cnt} + {1'b0, r_err_cnt};
    assign w_idx = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_vld <= '0;
        end else if (i_clear) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_valid;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Golden data needs no reset: it is only looked at behind a valid bit.
    always_ff @(posedge i_clk) begin
        r_add[0] <= w_exp_add;
        r_mul[0] <= w_exp_mul;
        for (int i = 1; i < LAT; i++) begin
            r_add[i] <= r_add[i-1];
            r_mul[i] <= r_mul[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state          <= ST_IDLE;
            r_pass_cnt       <= '0;
            r_err_cnt        <= '0;
            r_err_flags      <= 2'b00;
            r_first_fail_idx <= '0;
        end else if (i_clear) begin
            r_state          <= ST_IDLE;
            r_pass_cnt       <= '0;
            r_err_cnt        <= '0;
            r_err_flags      <= 2'b00;
            r_first_fail_idx <= '0;
        end else begin
            if (w_cmp_en) begin
                if (!w_any_bad) begin
                    if (r_pass_cnt != '1) begin
                        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                    r_err_flags <= r_err_flags | {w_mul_bad, w_add_bad};
                    if (r_err_flags == 2'b00) begin
                        r_first_fail_idx <= w_idx;
                    end
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((STOP_ON_ERR != 0) && w_cmp_en && w_any_bad) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_pass_cnt       = r_pass_cnt;
    assign o_err_cnt        = r_err_cnt;
    assign o_err_flags      = r_err_flags;
    assign o_first_fail_idx = r_first_fail_idx;
    assign o_busy           = |r_vld;

endmodule
